// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle control unit: exe commands, modes,
// opcodes, op-kind and FSM state enums.
package mcu_pkg;

    localparam logic [3:0] EXE_NOP    = 4'b0000;
    localparam logic [3:0] EXE_MOV    = 4'b0001;
    localparam logic [3:0] EXE_ADD    = 4'b0010;
    localparam logic [3:0] EXE_ADC    = 4'b0011;
    localparam logic [3:0] EXE_SUB    = 4'b0100;
    localparam logic [3:0] EXE_SBC    = 4'b0101;
    localparam logic [3:0] EXE_AND    = 4'b0110;
    localparam logic [3:0] EXE_ORR    = 4'b0111;
    localparam logic [3:0] EXE_EOR    = 4'b1000;
    localparam logic [3:0] EXE_MVN    = 4'b1001;
    localparam logic [3:0] EXE_MUL_LO = 4'b1100;
    localparam logic [3:0] EXE_MUL_HI = 4'b1101;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_STK = 2'b11;

    localparam logic [3:0] OPC_AND  = 4'b0000;
    localparam logic [3:0] OPC_EOR  = 4'b0001;
    localparam logic [3:0] OPC_SUB  = 4'b0010;
    localparam logic [3:0] OPC_WADD = 4'b0011;
    localparam logic [3:0] OPC_ADD  = 4'b0100;
    localparam logic [3:0] OPC_ADC  = 4'b0101;
    localparam logic [3:0] OPC_SBC  = 4'b0110;
    localparam logic [3:0] OPC_TST  = 4'b1000;
    localparam logic [3:0] OPC_MUL  = 4'b1001;
    localparam logic [3:0] OPC_CMP  = 4'b1010;
    localparam logic [3:0] OPC_ORR  = 4'b1100;
    localparam logic [3:0] OPC_MOV  = 4'b1101;
    localparam logic [3:0] OPC_MVN  = 4'b1111;

    typedef enum logic [2:0] {K_NONE, K_WADD, K_PUSH, K_POP, K_MUL} op_kind_e;
    typedef enum logic {S_IDLE, S_BUSY} state_e;

    // Index of the final micro-op for a given sequence kind.
    function automatic int f_last_idx(input op_kind_e kind, input int chunks);
        case (kind)
            K_WADD:  return chunks - 1;
            K_NONE:  return 0;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Decode-side bundle: instruction fields in, control word and sequencer status out.
interface multicycle_control_unit_if #(parameter int CNT_W = 3);
    logic [1:0]       mode;
    logic [3:0]       opcode;
    logic             status;
    logic             hazard;
    logic             flush;
    logic [3:0]       exe_cmd;
    logic             mem_read;
    logic             mem_write;
    logic             wb_en;
    logic             branch;
    logic             status_update;
    logic             freeze;
    logic             sp_sel;
    logic [CNT_W-1:0] uop_idx;
    logic             busy;

    modport master (
        output mode, opcode, status, hazard, flush,
        input  exe_cmd, mem_read, mem_write, wb_en, branch, status_update,
               freeze, sp_sel, uop_idx, busy
    );

    modport slave (
        input  mode, opcode, status, hazard, flush,
        output exe_cmd, mem_read, mem_write, wb_en, branch, status_update,
               freeze, sp_sel, uop_idx, busy
    );
endinterface

// File: rtl/mcu_seq_counter.sv
// Two-state micro-op sequencer: the first uop issues from IDLE, BUSY walks the rest.
module mcu_seq_counter
    import mcu_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_hold,
    input  logic             i_clear,
    input  logic             i_tc,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_busy
);
    state_e           r_state;
    logic [CNT_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start && !i_clear) begin
                    r_state <= S_BUSY;
                    r_idx   <= CNT_W'(1);
                end
                S_BUSY: if (i_clear || (!i_hold && i_tc)) begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                end else if (!i_hold) begin
                    r_idx   <= r_idx + CNT_W'(1);
                end
            endcase
        end
    end

    assign o_idx  = r_idx;
    assign o_busy = (r_state == S_BUSY);
endmodule

// File: rtl/multicycle_control_unit.sv
// Control unit: combinational decode plus multi-cycle WADD/PUSH/POP sequencing.
// Define MCU_MUL_EN to add the two-uop MUL instruction.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int WADD_CHUNKS = 2,
    parameter int CNT_W       = 3
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.slave bus
);
    op_kind_e         w_kind, w_act, r_kind;
    logic             w_busy, w_start, w_last, w_kill;
    logic [CNT_W-1:0] w_idx;
    logic [3:0]       w_exe;
    logic             w_mr, w_mw, w_wb, w_br, w_su, w_frz, w_sp;

    always_comb begin
        w_kind = K_NONE;
        if (bus.mode == MODE_ALU && bus.opcode == OPC_WADD) w_kind = K_WADD;
        else if (bus.mode == MODE_STK) w_kind = bus.status ? K_POP : K_PUSH;
`ifdef MCU_MUL_EN
        else if (bus.mode == MODE_ALU && bus.opcode == OPC_MUL) w_kind = K_MUL;
`endif
    end

    // In BUSY the latched kind drives the uops; new instruction fields are ignored.
    assign w_act   = w_busy ? r_kind : w_kind;
    assign w_last  = (int'(w_idx) == f_last_idx(w_act, WADD_CHUNKS));
    assign w_start = !w_busy && (w_kind != K_NONE) && !bus.hazard && !bus.flush;
    assign w_kill  = rst || bus.flush;

    mcu_seq_counter #(.CNT_W(CNT_W)) u_seq (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_hold (bus.hazard),
        .i_clear(bus.flush),
        .i_tc   (w_last),
        .o_idx  (w_idx),
        .o_busy (w_busy)
    );

    always_ff @(posedge clk) begin
        if (rst)                                             r_kind <= K_NONE;
        else if (w_start)                                    r_kind <= w_kind;
        else if (w_busy && (bus.flush || (!bus.hazard && w_last))) r_kind <= K_NONE;
    end

    always_comb begin
        w_exe = EXE_NOP;
        w_mr  = 1'b0; w_mw = 1'b0; w_wb  = 1'b0; w_br = 1'b0;
        w_su  = 1'b0; w_frz = 1'b0; w_sp = 1'b0;
        if (w_act != K_NONE) begin
            case (w_act)
                K_WADD: begin
                    w_exe = (w_idx == '0) ? EXE_ADD : EXE_ADC;
                    w_wb  = 1'b1;
                    w_su  = w_last && bus.status;
                end
                K_PUSH: begin
                    w_sp = 1'b1;
                    if (w_idx == '0) begin w_exe = EXE_SUB; w_wb = 1'b1; end
                    else begin w_exe = EXE_ADD; w_mw = 1'b1; end
                end
                K_POP: begin
                    w_sp  = 1'b1;
                    w_exe = EXE_ADD;
                    w_wb  = 1'b1;
                    w_mr  = (w_idx == '0);
                end
`ifdef MCU_MUL_EN
                K_MUL: begin
                    w_exe = (w_idx == '0) ? EXE_MUL_LO : EXE_MUL_HI;
                    w_wb  = 1'b1;
                end
`endif
                default: ;
            endcase
            w_frz = !w_last;
        end else begin
            case (bus.mode)
                MODE_ALU: begin
                    w_wb = 1'b1;
                    w_su = bus.status;
                    case (bus.opcode)
                        OPC_MOV: w_exe = EXE_MOV;
                        OPC_MVN: w_exe = EXE_MVN;
                        OPC_ADD: w_exe = EXE_ADD;
                        OPC_ADC: w_exe = EXE_ADC;
                        OPC_SUB: w_exe = EXE_SUB;
                        OPC_SBC: w_exe = EXE_SBC;
                        OPC_AND: begin w_exe = EXE_AND; w_su = 1'b0; end
                        OPC_ORR: w_exe = EXE_ORR;
                        OPC_EOR: w_exe = EXE_EOR;
                        OPC_CMP: begin w_exe = EXE_SUB; w_wb = 1'b0; w_su = 1'b1; end
                        OPC_TST: begin w_exe = EXE_AND; w_wb = 1'b0; w_su = 1'b1; end
                        default: begin w_wb = 1'b0; w_su = 1'b0; end
                    endcase
                end
                MODE_MEM: begin
                    w_exe = EXE_ADD;
                    w_su  = bus.status;
                    if (bus.status) begin w_mr = 1'b1; w_wb = 1'b1; end
                    else w_mw = 1'b1;
                end
                MODE_BR: begin w_br = 1'b1; w_su = bus.status; end
                default: ;
            endcase
        end
        if (bus.hazard) begin
            w_exe = EXE_NOP;
            w_mr  = 1'b0; w_mw = 1'b0; w_wb = 1'b0; w_br = 1'b0;
            w_su  = 1'b0; w_sp = 1'b0; w_frz = 1'b1;
        end
    end

    assign bus.exe_cmd       = w_kill ? EXE_NOP : w_exe;
    assign bus.mem_read      = !w_kill && w_mr;
    assign bus.mem_write     = !w_kill && w_mw;
    assign bus.wb_en         = !w_kill && w_wb;
    assign bus.branch        = !w_kill && w_br;
    assign bus.status_update = !w_kill && w_su;
    assign bus.freeze        = !w_kill && w_frz;
    assign bus.sp_sel        = !w_kill && w_sp;
    assign bus.busy          = !w_kill && w_busy;
    assign bus.uop_idx       = w_kill ? '0 : w_idx;
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter WADD_CHUNKS, default 2, legal range 2..8: number of 32-bit chunks in a wide add.
REQ-002 SHALL have parameter CNT_W, default 3: micro-op index width, at least clog2(WADD_CHUNKS).
REQ-003 SHALL have ports `clk` (input, 1, sole clock) and `rst` (input, 1, reset); one clock, reset synchronous active-high.
REQ-004 SHALL have inputs `mode` (2, instruction class), `opcode` (4), `status` (1: S bit / L bit), `hazard` (1: operand hazard) and `flush` (1: taken branch kills sequence).
REQ-005 SHALL have outputs `exe_cmd` (4), `mem_read`, `mem_write`, `wb_en`, `branch` and `status_update`, each 1 bit.
REQ-006 SHALL have outputs `freeze` (1: hold fetch/decode), `sp_sel` (1: use SP as operand/destination), `uop_idx` (CNT_W: current micro-op) and `busy` (1: sequence in progress).

Function
REQ-007 In IDLE, single-cycle ops SHALL decode combinationally. Mode 00: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000 (all wb_en=1); CMP 1010->0100 and TST 1000->0110 (wb_en=0). Mode 01: exe 0010; status=1 -> mem_read=wb_en=1; status=0 -> mem_write=1. Mode 10: branch=1, exe 0000.
REQ-008 Unlisted encodings SHALL decode as a NOP: all outputs 0.
REQ-009 status_update SHALL be 1 for CMP/TST, 0 for mode-00 opcode 0000, and status otherwise.
REQ-010 Multi-cycle ops: WADD (mode 00, opcode 0011) runs WADD_CHUNKS uops; PUSH (mode 11, status 0) and POP (mode 11, status 1) run 2 uops each.
REQ-011 FSM SHALL have exactly two states. IDLE goes to BUSY when a multi-cycle op is decoded with hazard=0 and flush=0; the op kind SHALL be latched and uop_idx SHALL go 0->1. BUSY increments uop_idx each non-stalled cycle and returns to IDLE after the last uop.
REQ-012 WADD uop k SHALL drive exe_cmd 0010 for k=0 and 0011 (ADC) for k>0, with wb_en=1. status_update SHALL equal status on the last chunk only.
REQ-013 PUSH: uop0 drives exe 0100, sp_sel=1, wb_en=1 (SP-=4). uop1 drives exe 0010, sp_sel=1, mem_write=1.
REQ-014 POP: uop0 drives exe 0010, sp_sel=1, mem_read=1, wb_en=1. uop1 drives exe 0010, sp_sel=1, wb_en=1 (SP+=4).
REQ-015 freeze SHALL be 1 in every uop cycle except the last; total latency is N cycles for an N-uop op.
REQ-016 While hazard=1: in IDLE, all outputs 0 except freeze=1 and no start; in BUSY, uop_idx holds, the issued outputs are 0, and freeze=1.
REQ-017 flush=1 SHALL force all outputs to 0 that cycle and return to IDLE next cycle with uop_idx=0; flush has priority over hazard and over a start.
REQ-018 uop_idx SHALL never exceed WADD_CHUNKS-1 and SHALL reset to 0 on sequence completion; busy=1 exactly in BUSY.

Reset
REQ-019 While rst=1, state SHALL be IDLE, uop_idx and the latched kind SHALL be 0, and all outputs SHALL be 0, including mid-sequence.
REQ-020 On the first cycle after reset deasserts, the unit SHALL decode normally.

Configuration
REQ-021 Macro MCU_MUL_EN SHALL be defined to compile in MUL (mode 00, opcode 1001): 2 uops, exe 1100 then 1101, wb_en=1 both, freeze on uop0.
REQ-022 With MCU_MUL_EN undefined, opcode 1001 SHALL decode as NOP and no MUL logic SHALL exist.

Structure
REQ-023 Shared package mcu_pkg SHALL hold the exe_cmd constants, mode encodings, the op-kind enum (NONE, WADD, PUSH, POP, MUL) and the state enum.
REQ-024 The counter/FSM SHALL be sub-module mcu_seq_counter (hold, clear and terminal-count inputs); decode SHALL stay in the top module.

Verification
REQ-025 ADD 0100, mode 00, status 1 -> same cycle: exe 0010, wb_en=1, status_update=1, freeze=0.
REQ-026 WADD with WADD_CHUNKS=4 -> 4 cycles, exe 0010,0011,0011,0011; freeze 1,1,1,0; status_update only on cycle 4.
REQ-027 PUSH with hazard=1 on uop1 for 2 cycles -> uop_idx holds at 1, outputs 0, freeze=1; then mem_write=1, sp_sel=1, freeze=0.
REQ-028 POP with flush=1 on uop1 -> outputs 0 that cycle, busy=0 and uop_idx=0 next cycle.
REQ-029 rst=1 in uop2 of WADD(4) -> all outputs 0 and IDLE; the next ADD decodes correctly.
REQ-030 Opcode 1001 -> exe 1100 then 1101 with MCU_MUL_EN defined; all outputs 0 with it undefined.
